// File: rtl/butterfly_pipe.sv
// butterfly_pipe: three-stage radix-2 DIT butterfly X = a + W*b, Y = a - W*b,
// using conj(W) in inverse mode, with rounding, optional /2 scaling and saturation.
module butterfly_pipe #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16,
    parameter int ROUND    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    a_re,
    input  logic signed [WIDTH-1:0]    a_im,
    input  logic signed [WIDTH-1:0]    b_re,
    input  logic signed [WIDTH-1:0]    b_im,
    input  logic signed [TW_WIDTH-1:0] w_re,
    input  logic signed [TW_WIDTH-1:0] w_im,
    input  logic                       inverse,
    input  logic                       scale,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    X_re,
    output logic signed [WIDTH-1:0]    X_im,
    output logic signed [WIDTH-1:0]    Y_re,
    output logic signed [WIDTH-1:0]    Y_im,
    output logic                       ovf,
    output logic                       ovf_sticky,
    input  logic                       ovf_clr
);
    localparam int P  = WIDTH + TW_WIDTH;
    localparam int SH = TW_WIDTH - 1;
    localparam int WB = WIDTH + 2;
    localparam int SW = WIDTH + 3;

    localparam logic signed [P:0]    HALF = (ROUND != 0) ? ({{P{1'b0}}, 1'b1} << (SH - 1)) : '0;
    localparam logic signed [SW-1:0] RONE = (ROUND != 0) ? {{(SW-1){1'b0}}, 1'b1} : '0;
    localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both 1;
    // the whole pipe advances together when the output slot is empty or being drained.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    function automatic logic signed [P-1:0] mul(input logic signed [TW_WIDTH:0] w,
                                                input logic signed [WIDTH-1:0]  b);
        logic signed [P-1:0] wx;
        logic signed [P-1:0] bx;
        wx = {{(P-TW_WIDTH-1){w[TW_WIDTH]}}, w};
        bx = {{(P-WIDTH){b[WIDTH-1]}}, b};
        return wx * bx;
    endfunction

    function automatic logic signed [P:0] ext_p(input logic signed [P-1:0] v);
        return {v[P-1], v};
    endfunction

    function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] v, input logic en);
        logic signed [SW-1:0] r;
        r = v + RONE;
        return en ? (r >>> 1) : v;
    endfunction

    // Returns {saturated, value}.
    function automatic logic [WIDTH:0] sat(input logic signed [SW-1:0] v);
        if (v > MAXV) return {1'b1, MAXV[WIDTH-1:0]};
        if (v < MINV) return {1'b1, MINV[WIDTH-1:0]};
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    // Conjugation happens on the widened twiddle so that negating the most negative value is exact.
    logic signed [TW_WIDTH:0] w_im_x;
    logic signed [TW_WIDTH:0] w_im_eff;
    assign w_im_x   = {w_im[TW_WIDTH-1], w_im};
    assign w_im_eff = inverse ? -w_im_x : w_im_x;

    logic                     s1_valid;
    logic signed [WIDTH-1:0]  s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic signed [TW_WIDTH:0] s1_w_re, s1_w_im;
    logic                     s1_scale;

    logic                     s2_valid;
    logic signed [WIDTH-1:0]  s2_a_re, s2_a_im;
    logic signed [P-1:0]      s2_p_rr, s2_p_ii, s2_p_ri, s2_p_ir;
    logic                     s2_scale;

    logic signed [P:0]        wr_t, wi_t;
    logic signed [WB-1:0]     wb_re, wb_im;
    logic signed [SW-1:0]     ax_re, ax_im, wx_re, wx_im;
    logic [WIDTH:0]           sat_xr, sat_xi, sat_yr, sat_yi;
    logic                     ovf_n;
    logic                     unused_bits;

    always_comb begin
        wr_t   = ext_p(s2_p_rr) - ext_p(s2_p_ii) + HALF;
        wi_t   = ext_p(s2_p_ri) + ext_p(s2_p_ir) + HALF;
        wb_re  = wr_t[P:SH];
        wb_im  = wi_t[P:SH];
        ax_re  = {{3{s2_a_re[WIDTH-1]}}, s2_a_re};
        ax_im  = {{3{s2_a_im[WIDTH-1]}}, s2_a_im};
        wx_re  = {wb_re[WB-1], wb_re};
        wx_im  = {wb_im[WB-1], wb_im};
        sat_xr = sat(scl(ax_re + wx_re, s2_scale));
        sat_xi = sat(scl(ax_im + wx_im, s2_scale));
        sat_yr = sat(scl(ax_re - wx_re, s2_scale));
        sat_yi = sat(scl(ax_im - wx_im, s2_scale));
        ovf_n  = sat_xr[WIDTH] | sat_xi[WIDTH] | sat_yr[WIDTH] | sat_yi[WIDTH];
    end

    assign unused_bits = ^{wr_t[SH-1:0], wi_t[SH-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a_re    <= '0;
            s1_a_im    <= '0;
            s1_b_re    <= '0;
            s1_b_im    <= '0;
            s1_w_re    <= '0;
            s1_w_im    <= '0;
            s1_scale   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_a_re    <= '0;
            s2_a_im    <= '0;
            s2_p_rr    <= '0;
            s2_p_ii    <= '0;
            s2_p_ri    <= '0;
            s2_p_ir    <= '0;
            s2_scale   <= 1'b0;
            out_valid  <= 1'b0;
            X_re       <= '0;
            X_im       <= '0;
            Y_re       <= '0;
            Y_im       <= '0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                s1_a_re   <= a_re;
                s1_a_im   <= a_im;
                s1_b_re   <= b_re;
                s1_b_im   <= b_im;
                s1_w_re   <= {w_re[TW_WIDTH-1], w_re};
                s1_w_im   <= w_im_eff;
                s1_scale  <= scale;
                s2_valid  <= s1_valid;
                s2_a_re   <= s1_a_re;
                s2_a_im   <= s1_a_im;
                s2_p_rr   <= mul(s1_w_re, s1_b_re);
                s2_p_ii   <= mul(s1_w_im, s1_b_im);
                s2_p_ri   <= mul(s1_w_re, s1_b_im);
                s2_p_ir   <= mul(s1_w_im, s1_b_re);
                s2_scale  <= s1_scale;
                out_valid <= s2_valid;
                if (s2_valid) begin
                    X_re <= sat_xr[WIDTH-1:0];
                    X_im <= sat_xi[WIDTH-1:0];
                    Y_re <= sat_yr[WIDTH-1:0];
                    Y_im <= sat_yi[WIDTH-1:0];
                    ovf  <= ovf_n;
                end
            end
            // A saturating result leaving the block outranks a simultaneous clear.
            if (out_valid && out_ready && ovf) ovf_sticky <= 1'b1;
            else if (ovf_clr)                  ovf_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vector table, stall/reset
// sequences and randomized flow control against an arithmetic reference model.
module tb_butterfly_pipe;
    localparam int W   = 16;
    localparam int TW  = 16;
    localparam int RND = 1;
    localparam int RW  = 4 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a_re, a_im, b_re, b_im;
    logic [TW-1:0] w_re, w_im;
    logic          inverse, scale;
    logic [W-1:0]  X_re, X_im, Y_re, Y_im;
    logic          ovf, ovf_sticky, ovf_clr;

    always #5 clk = ~clk;

    butterfly_pipe #(.WIDTH(W), .TW_WIDTH(TW), .ROUND(RND)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im), .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .X_re(X_re), .X_im(X_im), .Y_re(Y_re), .Y_im(Y_im),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic signed [W-1:0]  a_re, a_im, b_re, b_im;
        logic signed [TW-1:0] w_re, w_im;
        logic                 inverse, scale;
    } txn_t;

    typedef struct {
        txn_t         t;
        logic [RW-1:0] res;
        logic         clr;
        logic         sticky;
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    int            n_acc = 0;
    int            n_out = 0;
    logic [RW-1:0] exp_q[$];
    txn_t          pend_q[$];
    logic [RW-1:0] got_w;
    txn_t          mon_t;
    logic [RW-1:0] mon_e;
    vec_t          vecs[9];

    assign got_w = {ovf, X_re, X_im, Y_re, Y_im};

    // Reference: exact integer arithmetic with floor-based shifts.
    function automatic logic [RW-1:0] model(input txn_t t);
        longint ar = t.a_re, ai = t.a_im, br = t.b_re, bi = t.b_im;
        longint wr = t.w_re;
        longint wi = t.inverse ? -longint'(t.w_im) : longint'(t.w_im);
        longint half = (RND != 0) ? (longint'(1) <<< (TW - 2)) : 0;
        longint maxv = (longint'(1) <<< (W - 1)) - 1;
        longint minv = -(longint'(1) <<< (W - 1));
        longint wbr, wbi;
        longint s[4];
        logic [W-1:0] v[4];
        logic o = 1'b0;
        wbr = (wr * br - wi * bi + half) >>> (TW - 1);
        wbi = (wr * bi + wi * br + half) >>> (TW - 1);
        s[0] = ar + wbr; s[1] = ai + wbi; s[2] = ar - wbr; s[3] = ai - wbi;
        for (int i = 0; i < 4; i++) begin
            if (t.scale) s[i] = (s[i] + RND) >>> 1;
            if (s[i] > maxv) begin s[i] = maxv; o = 1'b1; end
            if (s[i] < minv) begin s[i] = minv; o = 1'b1; end
            v[i] = s[i][W-1:0];
        end
        return {o, v[0], v[1], v[2], v[3]};
    endfunction

    function automatic txn_t mk(input logic [W-1:0] ar, ai, br, bi,
                                input logic [TW-1:0] wr, wi, input logic inv, sc);
        txn_t t;
        t.a_re = ar; t.a_im = ai; t.b_re = br; t.b_im = bi;
        t.w_re = wr; t.w_im = wi; t.inverse = inv; t.scale = sc;
        return t;
    endfunction

    function automatic vec_t mkv(input txn_t t, input logic [W-1:0] xr, xi, yr, yi,
                                 input logic o, clr, sticky);
        vec_t v;
        v.t = t; v.res = {o, xr, xi, yr, yi}; v.clr = clr; v.sticky = sticky;
        return v;
    endfunction

    function automatic logic [15:0] rc();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return r[15:0];
        endcase
    endfunction

    function automatic txn_t rand_txn();
        return mk(rc(), rc(), rc(), rc(), rc(), rc(), 1'($urandom_range(1)), 1'($urandom_range(1)));
    endfunction

    task automatic drive(input txn_t t);
        a_re = t.a_re; a_im = t.a_im; b_re = t.b_re; b_im = t.b_im;
        w_re = t.w_re; w_im = t.w_im; inverse = t.inverse; scale = t.scale;
    endtask

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Scoreboard: expected results are queued at input handshakes, checked at output handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                mon_t.a_re = a_re; mon_t.a_im = a_im; mon_t.b_re = b_re; mon_t.b_im = b_im;
                mon_t.w_re = w_re; mon_t.w_im = w_im; mon_t.inverse = inverse; mon_t.scale = scale;
                exp_q.push_back(model(mon_t));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard: unexpected output %h, required none", got_w);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (got_w !== mon_e) begin
                        bad++;
                        $display("FAIL scoreboard: got %h required %h", got_w, mon_e);
                    end
                end
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic run_cycles(input int n, input int pv, input int pr);
        txn_t dump;
        for (int i = 0; i < n; i++) begin
            if (pend_q.size() > 0 && $urandom_range(99) < pv) begin
                drive(pend_q[0]); in_valid = 1'b1;
            end else begin
                drive(rand_txn()); in_valid = 1'b0;
            end
            out_ready = ($urandom_range(99) < pr);
            @(negedge clk);
            if (in_valid && in_ready) dump = pend_q.pop_front();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output int cnt);
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check(name, RW'(cnt), RW'(3));
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int cnt;
        drive(v.t); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d accept", idx), RW'(in_ready), RW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out($sformatf("vec%0d latency", idx), cnt);
        check($sformatf("vec%0d result", idx), got_w, v.res);
        ovf_clr = v.clr;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check($sformatf("vec%0d sticky", idx), RW'(ovf_sticky), RW'(v.sticky));
    endtask

    initial begin
        logic [RW-1:0] snap;
        txn_t t;
        int cyc, cnt;

        vecs[0] = mkv(mk(16'h2000, 0, 16'h2000, 0, 16'h7FFF, 0, 0, 0), 16'h4000, 0, 16'h0000, 0, 0, 0, 0);
        vecs[1] = mkv(mk(0, 0, 16'h2000, 0, 0, 16'h7FFF, 0, 0), 0, 16'h2000, 0, 16'hE000, 0, 0, 0);
        vecs[2] = mkv(mk(0, 0, 16'h2000, 0, 0, 16'h7FFF, 1, 0), 0, 16'hE000, 0, 16'h2000, 0, 0, 0);
        vecs[3] = mkv(mk(16'h7FFF, 0, 16'h7FFF, 0, 16'h7FFF, 0, 0, 0), 16'h7FFF, 0, 16'h0001, 0, 1, 1, 1);
        vecs[4] = mkv(mk(16'h7FFF, 0, 16'h7FFF, 0, 16'h7FFF, 0, 0, 1), 16'h7FFF, 0, 16'h0001, 0, 0, 0, 1);
        vecs[5] = mkv(mk(16'h7FFF, 0, 16'h7FFF, 0, 16'h7FFF, 0, 0, 1), 16'h7FFF, 0, 16'h0001, 0, 0, 1, 0);
        vecs[6] = mkv(mk(0, 0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 0), 0, 16'h7FFF, 0, 16'h8000, 1, 0, 1);
        vecs[7] = mkv(mk(0, 0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1, 0), 16'h7FFF, 0, 16'h8000, 0, 1, 0, 1);
        vecs[8] = mkv(mk(16'h0001, 16'hFFFF, 0, 0, 0, 0, 0, 1), 16'h0001, 0, 16'h0001, 0, 0, 1, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("reset out_valid", RW'(out_valid), RW'(0));
        check("reset in_ready", RW'(in_ready), RW'(1));
        check("reset data", got_w, '0);
        check("reset sticky", RW'(ovf_sticky), RW'(0));

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

        // Stall with a full pipe, then release.
        for (int i = 0; i < 8; i++) pend_q.push_back(rand_txn());
        run_cycles(8, 100, 0);
        check("stall accepted", RW'(8 - pend_q.size()), RW'(3));
        check("stall in_ready", RW'(in_ready), RW'(0));
        check("stall out_valid", RW'(out_valid), RW'(1));
        snap = got_w;
        run_cycles(4, 100, 0);
        check("stall hold data", got_w, snap);
        check("stall hold count", RW'(pend_q.size()), RW'(5));
        run_cycles(1, 100, 100);
        check("release accept", RW'(pend_q.size()), RW'(4));
        run_cycles(30, 100, 100);
        check("stall drain pend", RW'(pend_q.size()), RW'(0));
        check("stall drain exp", RW'(exp_q.size()), RW'(0));

        // Random flow control.
        for (int k = 0; k < 10000; k++) begin
            t = rand_txn();
            if (k % 97 == 0) begin
                t.w_re = 16'h8000; t.w_im = 16'h8000; t.b_re = 16'h8000; t.b_im = 16'h8000;
            end
            pend_q.push_back(t);
        end
        cyc = 0;
        while (pend_q.size() > 0 && cyc < 60000) begin
            run_cycles(100, $urandom_range(30, 100), $urandom_range(30, 100));
            cyc += 100;
        end
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("random all sent", RW'(pend_q.size()), RW'(0));
        check("random all out", RW'(exp_q.size()), RW'(0));
        check("random count", RW'(n_out), RW'(n_acc));

        // Reset with transactions in flight.
        apply_vec(vecs[3], 3);
        for (int i = 0; i < 3; i++) pend_q.push_back(rand_txn());
        run_cycles(3, 100, 0);
        check("pre-reset loaded", RW'(pend_q.size()), RW'(0));
        #2 rst = 1'b1;
        exp_q.delete();
        pend_q.delete();
        #1;
        check("async out_valid", RW'(out_valid), RW'(0));
        check("async data", got_w, '0);
        check("async sticky", RW'(ovf_sticky), RW'(0));
        @(posedge clk); #2 rst = 1'b0;
        n_acc = 0; n_out = 0;
        @(posedge clk); #1;
        drive(rand_txn()); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("post-reset latency", cnt);
        repeat (3) @(posedge clk);
        #1;
        check("post-reset out", RW'(n_out), RW'(1));
        check("post-reset exp", RW'(exp_q.size()), RW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
